vga_image_fetch: RTL and testbench

- Pixel-fetch stage between the display image RAM and the VGA output pins. It sits directly upstream of the pin-level r/g/b/hsync/vsync/blank_b outputs and downstream of the VGA timing generator's x/y counters.
- Converts the current VGA coordinate into an image-RAM read address and centres an IMG_W x IMG_H 8-bit grayscale image on the 640x480 screen.
- Absorbs the RAM read latency by delaying the sync and blank signals by the same number of pixels, and replicates the gray value onto r, g and b.
- Gates display of the processor's equalized image through a frame-synchronous handshake, so a frame is never shown half-old, half-new.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_image_fetch_if.sv | 11 +
 rtl/delay_line.sv | 27 ++
 rtl/vga_image_fetch.sv | 128 ++++++++++++
 tb/tb_vga_image_fetch.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types for the VGA image fetch stage
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SHOW
    } fetch_state_t;

    typedef logic [9:0] coord_t;

    // Per-pixel side information carried alongside the RAM read.
    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       active;
        logic       in_win;
        logic       src_sel;
        logic [7:0] xoff;
    } pix_tag_t;

endpackage

// File: rtl/vga_image_fetch_if.sv
// rtl/vga_image_fetch_if.sv - image RAM read port
interface vga_image_fetch_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata;

    modport master (output mem_addr, output mem_rd, input mem_rdata);
    modport slave  (input mem_addr, input mem_rd, output mem_rdata);
endinterface

// File: rtl/delay_line.sv
// rtl/delay_line.sv - enable-gated shift register with per-bit reset value
module delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= RST_VAL;
        end else if (en) begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/vga_image_fetch.sv
// rtl/vga_image_fetch.sv - centres a RAM image on screen and gates it per frame
module vga_image_fetch
    import vga_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int X0     = 192,
    parameter int Y0     = 112,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  coord_t      x,
    input  coord_t      y,
    input  logic        active_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        img_valid,
    vga_image_fetch_if.master mem,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_b,
    output logic        showing,
    output logic [15:0] frame_cnt
);

    localparam int L  = RD_LAT + 1;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = ADDR_W - XW;
    localparam pix_tag_t TAG_RST = '{hsync: 1'b1, vsync: 1'b1, default: '0};

    fetch_state_t state, state_nx;
    logic         vsync_q;
    logic         frame_start;
    logic         cnt_inc;
    coord_t       dx, dy;
    logic         in_win;
    logic         src_show;
    pix_tag_t     tag_d, tag_q;
    logic [7:0]   pix;

    // Negative offsets wrap to large unsigned values and fall outside the window.
    assign dx       = x - coord_t'(X0);
    assign dy       = y - coord_t'(Y0);
    assign in_win   = active_in && (dx < coord_t'(IMG_W)) && (dy < coord_t'(IMG_H));
    assign src_show = (state == SHOW);

    assign frame_start = pix_en && vsync_q && !vsync_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            vsync_q   <= 1'b1;
            frame_cnt <= '0;
        end else begin
            state <= state_nx;
            if (pix_en) vsync_q <= vsync_in;
            if (cnt_inc) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Arming may happen on any cycle; every other move waits for a frame start.
    always_comb begin
        state_nx = state;
        cnt_inc  = 1'b0;
        case (state)
            IDLE:  if (img_valid) state_nx = ARMED;
            ARMED: if (frame_start) state_nx = img_valid ? SHOW : IDLE;
            SHOW: begin
                if (frame_start) begin
                    cnt_inc = 1'b1;
                    if (!img_valid) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem.mem_addr <= '0;
            mem.mem_rd   <= 1'b0;
        end else if (pix_en) begin
            mem.mem_addr <= {dy[YW-1:0], dx[XW-1:0]};
            mem.mem_rd   <= in_win && src_show;
        end
    end

    assign tag_d = '{hsync:   hsync_in,
                     vsync:   vsync_in,
                     active:  active_in,
                     in_win:  in_win,
                     src_sel: src_show,
                     xoff:    dx[7:0]};

    delay_line #(
        .WIDTH   ($bits(pix_tag_t)),
        .DEPTH   (L),
        .RST_VAL (TAG_RST)
    ) u_tag_dly (
        .clk   (clk),
        .rst_n (rst),
        .en    (pix_en),
        .d     (tag_d),
        .q     (tag_q)
    );

    // RAM data arrives in the same pulse the tag leaves the delay line.
    always_comb begin
        pix = 8'd0;
        if (tag_q.active && tag_q.in_win)
            pix = tag_q.src_sel ? mem.mem_rdata : tag_q.xoff;
    end

    assign r       = pix;
    assign g       = pix;
    assign b       = pix;
    assign hsync   = tag_q.hsync;
    assign vsync   = tag_q.vsync;
    assign blank_b = tag_q.active;
    assign showing = tag_q.src_sel;

endmodule

// File: tb/tb_vga_image_fetch.sv
// tb/tb_vga_image_fetch.sv - bench for vga_image_fetch at RD_LAT 1 and 2
module tb_vga_image_fetch;
    import vga_pkg::*;

    logic   clk = 1'b0;
    always #5 clk = ~clk;

    logic   rst, pix_en, active_in, hsync_in, vsync_in, img_valid;
    coord_t x, y;

    logic [7:0]  r1, g1, b1, r2, g2, b2;
    logic        hsync1, vsync1, blank1, show1;
    logic        hsync2, vsync2, blank2, show2;
    logic [15:0] fc1, fc2;

    vga_image_fetch_if #(.ADDR_W(16)) mif1 ();
    vga_image_fetch_if #(.ADDR_W(16)) mif2 ();

    vga_image_fetch #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .pix_en(pix_en), .x(x), .y(y),
        .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .img_valid(img_valid), .mem(mif1),
        .r(r1), .g(g1), .b(b1), .hsync(hsync1), .vsync(vsync1),
        .blank_b(blank1), .showing(show1), .frame_cnt(fc1)
    );

    vga_image_fetch #(.RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .pix_en(pix_en), .x(x), .y(y),
        .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .img_valid(img_valid), .mem(mif2),
        .r(r2), .g(g2), .b(b2), .hsync(hsync2), .vsync(vsync2),
        .blank_b(blank2), .showing(show2), .frame_cnt(fc2)
    );

    function automatic logic [7:0] ram(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    logic [7:0] p1, p2a, p2b;
    always @(posedge clk) begin
        if (pix_en) begin
            p1  <= ram(mif1.mem_addr);
            p2a <= ram(mif2.mem_addr);
            p2b <= p2a;
        end
    end
    assign mif1.mem_rdata = p1;
    assign mif2.mem_rdata = p2b;

    typedef struct {
        logic        hs, vs, act, win, src;
        logic [7:0]  xoff;
        logic [15:0] addr;
    } rec_t;

    rec_t        hist[$];
    bit          m_armed, m_ram, m_vsq;
    logic [15:0] m_cnt;
    int          tests, fails;
    int          hs_low1, hs_low2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_armed = 0;
        m_ram   = 0;
        m_vsq   = 1;
        m_cnt   = 16'd0;
    endtask

    task automatic model_clock();
        rec_t       e;
        logic [9:0] dx, dy;
        bit         fs;
        if (!rst) begin
            model_reset();
        end else begin
            fs = pix_en && m_vsq && !vsync_in;
            if (pix_en) begin
                dx     = x - 10'd192;
                dy     = y - 10'd112;
                e.hs   = hsync_in;
                e.vs   = vsync_in;
                e.act  = active_in;
                e.win  = active_in && (dx < 10'd256) && (dy < 10'd256);
                e.src  = m_ram;
                e.xoff = dx[7:0];
                e.addr = {dy[7:0], dx[7:0]};
                hist.push_back(e);
                if (hist.size() > 4) void'(hist.pop_front());
                m_vsq = vsync_in;
            end
            if (!m_armed && !m_ram) begin
                if (img_valid) m_armed = 1;
            end else if (m_armed) begin
                if (fs) begin
                    m_armed = 0;
                    m_ram   = img_valid;
                end
            end else if (fs) begin
                m_cnt = m_cnt + 16'd1;
                m_ram = img_valid;
            end
        end
    endtask

    task automatic check_dut(input int lat, input string nm,
                             input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                             input logic hs, input logic vs, input logic bl, input logic sh,
                             input logic [15:0] fc, input logic [15:0] addr, input logic rd);
        rec_t       e;
        logic [7:0] px;
        logic       ehs, evs, ebl, esh;
        ehs = 1; evs = 1; ebl = 0; esh = 0; px = 8'd0;
        if (hist.size() >= lat + 1) begin
            e   = hist[hist.size() - (lat + 1)];
            ehs = e.hs;
            evs = e.vs;
            ebl = e.act;
            esh = e.src;
            if (e.win) px = e.src ? ram(e.addr) : e.xoff;
        end
        chk({nm, ".r"}, rr, px);
        chk({nm, ".g"}, gg, px);
        chk({nm, ".b"}, bb, px);
        chk({nm, ".hsync"}, hs, ehs);
        chk({nm, ".vsync"}, vs, evs);
        chk({nm, ".blank_b"}, bl, ebl);
        chk({nm, ".showing"}, sh, esh);
        chk({nm, ".frame_cnt"}, fc, m_cnt);
        chk({nm, ".mem_addr"}, addr, hist.size() == 0 ? 16'd0 : hist[$].addr);
        chk({nm, ".mem_rd"}, rd, hist.size() == 0 ? 1'b0 : (hist[$].win && hist[$].src));
    endtask

    task automatic step(input bit pe);
        pix_en = pe;
        @(posedge clk);
        model_clock();
        #1;
        if (pe) begin
            if (!hsync1) hs_low1++;
            if (!hsync2) hs_low2++;
        end
        check_dut(1, "d1", r1, g1, b1, hsync1, vsync1, blank1, show1, fc1, mif1.mem_addr, mif1.mem_rd);
        check_dut(2, "d2", r2, g2, b2, hsync2, vsync2, blank2, show2, fc2, mif2.mem_addr, mif2.mem_rd);
    endtask

    task automatic pixel(input int px, input int py, input bit act, input bit hs, input bit vs);
        x = coord_t'(px);
        y = coord_t'(py);
        active_in = act;
        hsync_in  = hs;
        vsync_in  = vs;
        step(1);
        repeat ($urandom_range(0, 2)) step(0);
    endtask

    task automatic filler();
        pixel(0, 0, 0, 1, 1);
    endtask

    task automatic rand_pixel();
        pixel($urandom_range(150, 520), $urandom_range(80, 400),
              ($urandom % 8) != 0, ($urandom % 16) != 0, 1);
    endtask

    task automatic frame_start(input bit arm);
        x = 10'd0; y = 10'd490; active_in = 0; hsync_in = 1; vsync_in = 0;
        if (arm) img_valid = 1;
        step(1);
        pixel(0, 491, 0, 1, 0);
        pixel(0, 492, 0, 1, 1);
    endtask

    initial begin
        tests = 0; fails = 0; hs_low1 = 0; hs_low2 = 0;
        rst = 0; pix_en = 0; x = '0; y = '0;
        active_in = 0; hsync_in = 1; vsync_in = 1; img_valid = 0;
        model_reset();
        repeat (2) step(0);
        chk("rst_r", r1, 8'h00);
        chk("rst_hsync", hsync2, 1'b1);
        chk("rst_blank", blank1, 1'b0);
        rst = 1;

        // Frame with no image: ramp pattern, no RAM reads.
        frame_start(0);
        pixel(202, 200, 1, 1, 1);
        filler();
        chk("ramp_d1", r1, 8'h0A);
        filler();
        chk("ramp_d2", g2, 8'h0A);
        pixel(100, 200, 1, 1, 1);
        filler();
        filler();
        chk("outside_d2", r2, 8'h00);
        pixel(192, 112, 1, 1, 1);
        chk("addr_first_d1", mif1.mem_addr, 16'h0000);
        chk("addr_first_d2", mif2.mem_addr, 16'h0000);
        pixel(447, 367, 1, 1, 1);
        chk("addr_last_d1", mif1.mem_addr, 16'hFFFF);
        chk("addr_last_d2", mif2.mem_addr, 16'hFFFF);
        filler();
        filler();
        filler();
        hs_low1 = 0; hs_low2 = 0;
        for (int i = 0; i < 96; i++) pixel(650 + i, 200, 0, 0, 1);
        repeat (3) filler();
        chk("hsync_width_d1", hs_low1, 96);
        chk("hsync_width_d2", hs_low2, 96);
        repeat (30) rand_pixel();

        // Image becomes valid mid-frame, between pixels.
        frame_start(0);
        repeat (20) rand_pixel();
        img_valid = 1;
        step(0);
        repeat (20) rand_pixel();
        chk("armed_not_showing", show1, 1'b0);

        // First frame sourced from RAM.
        frame_start(0);
        pixel(441, 112, 1, 1, 1);
        chk("mem_rd_in_show", mif1.mem_rd, 1'b1);
        filler();
        chk("ram_pix_d1", r1, 8'h5C);
        chk("showing_d1", show1, 1'b1);
        filler();
        chk("ram_pix_d2", b2, 8'h5C);
        chk("showing_d2", show2, 1'b1);
        pixel(448, 367, 1, 1, 1);
        chk("mem_rd_edge", mif1.mem_rd, 1'b0);
        repeat (30) rand_pixel();

        // Drop img_valid mid-frame: this frame still from RAM.
        frame_start(0);
        chk("frame_cnt_1", fc1, 16'd1);
        repeat (15) rand_pixel();
        img_valid = 0;
        pixel(300, 300, 1, 1, 1);
        repeat (20) rand_pixel();
        chk("show_after_drop", show2, 1'b1);

        frame_start(0);
        chk("frame_cnt_2", fc2, 16'd2);
        repeat (20) rand_pixel();
        chk("back_to_ramp", show1, 1'b0);

        // img_valid rising on the frame-start pulse only arms.
        frame_start(1);
        repeat (20) rand_pixel();
        chk("coincident_arm", show2, 1'b0);
        frame_start(0);
        repeat (20) rand_pixel();

        // Asynchronous reset mid-frame.
        pixel(320, 240, 1, 1, 1);
        #2 rst = 0;
        #1;
        model_reset();
        chk("async_r", r1, 8'h00);
        chk("async_hsync", hsync2, 1'b1);
        chk("async_blank", blank2, 1'b0);
        chk("async_showing", show1, 1'b0);
        chk("async_cnt", fc1, 16'd0);
        chk("async_mem_rd", mif2.mem_rd, 1'b0);
        repeat (2) step(0);
        rst = 1;
        repeat (10) rand_pixel();
        chk("post_rst_armed", show1, 1'b0);
        frame_start(0);
        repeat (10) rand_pixel();
        chk("post_rst_show", show2, 1'b1);

        // Arm, then withdraw before the frame start.
        frame_start(0);
        repeat (10) rand_pixel();
        img_valid = 0;
        frame_start(0);
        repeat (5) rand_pixel();
        img_valid = 1;
        step(0);
        img_valid = 0;
        frame_start(0);
        repeat (10) rand_pixel();
        chk("armed_withdrawn", show1, 1'b0);
        chk("armed_withdrawn_cnt", fc2, 16'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
